// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus fabric: FSM encoding and error causes.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Index width covers the 8-slave maximum; counter width covers TIMEOUT up to 65535.
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

endpackage

// File: rtl/soc_bus_decoder.sv
// Combinational address decode: mask/compare per slave, lowest index wins on overlap.
module soc_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int                   N_SLV    = 4,
  parameter logic [N_SLV*32-1:0]  SLV_BASE = '0,
  parameter logic [N_SLV*32-1:0]  SLV_MASK = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest matching slave overwrites any higher one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((addr & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master to N-slave bus fabric for the picorv32 native interface, with
// per-slave fixed latency, transaction timeout and a sticky error record.
//
//   state   | meaning
//   IDLE    | waiting for m_valid; decode address
//   BUSY    | slave selected, waiting for ready / fixed latency / timeout
//   RESP    | one-cycle m_ready with captured or error data
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h0040_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'hFFF0_0000}},
  parameter logic [N_SLV*4-1:0]  SLV_LAT  = {4'd0, 4'd0, 4'd0, 4'd1},
  parameter int                  TIMEOUT  = 255,
  parameter logic [31:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_valid,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [3:0]            m_wstrb,
  output logic                  m_ready,
  output logic [31:0]           m_rdata,
  output logic [N_SLV-1:0]      s_valid,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic [N_SLV-1:0]      s_ready,
  input  logic [N_SLV*32-1:0]   s_rdata,
  input  logic                  err_clr,
  output logic                  err_irq,
  output logic [1:0]            err_code,
  output logic [31:0]           err_addr
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic [3:0]         sel_lat;
  logic               done;
  logic               tmo;
  logic               err_evt;
  logic [1:0]         err_new;

  soc_bus_decoder #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign s_addr  = m_addr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign err_irq = (err_code != ERR_NONE);

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    sel_lat   = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = s_ready[k];
        sel_rdata = s_rdata[k*32 +: 32];
        sel_lat   = SLV_LAT[k*4 +: 4];
      end
    end
  end

  // Fixed-latency slaves complete at the end of their Lth BUSY cycle (counter = L-1).
  assign done = (sel_lat == 4'd0) ? sel_ready
                                  : (cnt_q == CNT_W'(sel_lat) - CNT_W'(1));
  assign tmo  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    err_evt = 1'b0;
    err_new = ERR_NONE;
    if (state_q == ST_IDLE && m_valid && !dec_hit) begin
      err_evt = 1'b1;
      err_new = ERR_UNMAPPED;
    end else if (state_q == ST_BUSY && !done && tmo) begin
      err_evt = 1'b1;
      err_new = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (m_valid) state_d = dec_hit ? ST_BUSY : ST_RESP;
      ST_BUSY: if (done || tmo) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_ready = (state_q == ST_RESP);
    m_rdata = m_ready ? rdata_q : 32'h0;
    s_valid = '0;
    for (int k = 0; k < N_SLV; k++) begin
      s_valid[k] = (state_q == ST_BUSY) && (idx_q == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m_valid && dec_hit) begin
            idx_q <= dec_idx;
            cnt_q <= '0;
          end else if (m_valid) begin
            rdata_q <= ERR_DATA;
          end
        end
        ST_BUSY: begin
          if (done)     rdata_q <= sel_rdata;
          else if (tmo) rdata_q <= ERR_DATA;
          else          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // First error is held; err_clr in the same cycle as a new error lets the new one in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else if (err_evt && (err_code == ERR_NONE || err_clr)) begin
      err_code <= err_new;
      err_addr <= m_addr;
    end else if (err_clr) begin
      err_code <= ERR_NONE;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: default map plus a second instance with overlapping regions.
module tb_soc_bus_fabric;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         err_clr;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;

  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic         err_irq;
  logic [1:0]   err_code;
  logic [31:0]  err_addr;

  logic         o_m_ready;
  logic [31:0]  o_m_rdata;
  logic [3:0]   o_s_valid;
  logic [31:0]  o_s_addr, o_s_wdata;
  logic [3:0]   o_s_wstrb;
  logic         o_err_irq;
  logic [1:0]   o_err_code;
  logic [31:0]  o_err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  soc_bus_fabric u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err_irq(err_irq), .err_code(err_code), .err_addr(err_addr)
  );

  soc_bus_fabric #(
    .SLV_BASE({32'h0040_0000, 32'h0010_0000, 32'h0010_0000, 32'h0000_0000})
  ) u_ovl (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(o_m_ready), .m_rdata(o_m_rdata),
    .s_valid(o_s_valid), .s_addr(o_s_addr), .s_wdata(o_s_wdata), .s_wstrb(o_s_wstrb),
    .s_ready(4'b1111), .s_rdata(128'h0),
    .err_clr(err_clr), .err_irq(o_err_irq), .err_code(o_err_code), .err_addr(o_err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
  endtask

  initial begin
    int hi_cnt;
    int mr_cyc;

    rst_n   = 1'b0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    err_clr = 1'b0;
    s_ready = '0;
    s_rdata = '0;
    repeat (2) tick();
    check("rst_m_ready",  32'(m_ready),  32'd0);
    check("rst_m_rdata",  m_rdata,       32'd0);
    check("rst_s_valid",  32'(s_valid),  32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_irq",  32'(err_irq),  32'd0);
    check("rst_err_addr", err_addr,      32'd0);
    rst_n = 1'b1;
    tick();

    // zero-wait read from slave 1; overlap instance must pick slave 1 only
    s_ready = 4'b0010;
    s_rdata[32 +: 32] = 32'h1234_5678;
    request(32'h0010_0004, 32'h0, 4'h0);
    check("rd_c0_s_valid", 32'(s_valid), 32'd0);
    tick();
    check("rd_c1_s_valid", 32'(s_valid), 32'b0010);
    check("rd_c1_m_ready", 32'(m_ready), 32'd0);
    check("rd_c1_m_rdata", m_rdata, 32'd0);
    check("rd_c1_s_addr",  s_addr,  32'h0010_0004);
    check("ovl_s_valid",   32'(o_s_valid), 32'b0010);
    tick();
    check("rd_c2_m_ready", 32'(m_ready), 32'd1);
    check("rd_c2_m_rdata", m_rdata, 32'h1234_5678);
    check("rd_c2_s_valid", 32'(s_valid), 32'd0);
    m_valid = 1'b0;
    tick();
    check("rd_c3_m_ready", 32'(m_ready), 32'd0);
    check("rd_c3_m_rdata", m_rdata, 32'd0);

    // slave 0 has fixed latency 1: s_ready is ignored
    s_ready = 4'b0000;
    s_rdata[0 +: 32] = 32'h0BAD_0000;
    request(32'h0000_0010, 32'hCAFE_F00D, 4'hF);
    tick();
    check("wr_c1_s_valid", 32'(s_valid), 32'b0001);
    check("wr_c1_s_wdata", s_wdata, 32'hCAFE_F00D);
    check("wr_c1_s_wstrb", 32'(s_wstrb), 32'hF);
    check("wr_c1_m_ready", 32'(m_ready), 32'd0);
    tick();
    check("wr_c2_m_ready", 32'(m_ready), 32'd1);
    check("wr_c2_s_valid", 32'(s_valid), 32'd0);
    check("wr_c2_m_rdata", m_rdata, 32'h0BAD_0000);
    m_valid = 1'b0;
    tick();

    // unmapped access
    request(32'h8000_0000, 32'h0, 4'h0);
    check("um_c0_s_valid", 32'(s_valid), 32'd0);
    tick();
    check("um_c1_m_ready",  32'(m_ready),  32'd1);
    check("um_c1_m_rdata",  m_rdata,       32'hDEAD_BEEF);
    check("um_c1_err_code", 32'(err_code), 32'd1);
    check("um_c1_err_addr", err_addr,      32'h8000_0000);
    check("um_c1_err_irq",  32'(err_irq),  32'd1);
    check("um_c1_s_valid",  32'(s_valid),  32'd0);
    m_valid = 1'b0;
    tick();
    check("um_c2_m_ready", 32'(m_ready), 32'd0);

    // second error while the first is still held
    request(32'h9000_0000, 32'h0, 4'h0);
    tick();
    m_valid = 1'b0;
    tick();
    check("held_err_addr", err_addr, 32'h8000_0000);
    check("held_err_code", 32'(err_code), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr1_err_irq",  32'(err_irq),  32'd0);
    check("clr1_err_code", 32'(err_code), 32'd0);

    // slave 2 never answers; other slaves' ready must not complete it
    s_ready = 4'b1011;
    request(32'h0020_0000, 32'h0, 4'h0);
    hi_cnt = 0;
    mr_cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (m_ready) begin
        mr_cyc = i;
        break;
      end
      if (s_valid == 4'b0100) hi_cnt++;
    end
    check("to_s_valid_cycles", 32'(hi_cnt), 32'd255);
    check("to_m_ready_cycle",  32'(mr_cyc), 32'd256);
    check("to_m_rdata",   m_rdata,       32'hDEAD_BEEF);
    check("to_err_code",  32'(err_code), 32'd2);
    check("to_err_addr",  err_addr,      32'h0020_0000);
    m_valid = 1'b0;
    s_ready = 4'b0000;
    tick();

    // clear coincident with a new error records the new one
    err_clr = 1'b1;
    request(32'hA000_0000, 32'h0, 4'h0);
    tick();
    err_clr = 1'b0;
    m_valid = 1'b0;
    check("clrnew_err_code", 32'(err_code), 32'd1);
    check("clrnew_err_addr", err_addr,      32'hA000_0000);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr2_err_irq", 32'(err_irq), 32'd0);

    // asynchronous reset in the middle of a slave 3 transaction
    request(32'h0040_0000, 32'h0, 4'h0);
    tick();
    check("ar_c1_s_valid", 32'(s_valid), 32'b1000);
    rst_n = 1'b0;
    #1;
    check("ar_s_valid", 32'(s_valid), 32'd0);
    check("ar_m_ready", 32'(m_ready), 32'd0);
    m_valid = 1'b0;
    s_ready = 4'b1000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_post_m_ready", 32'(m_ready), 32'd0);
    tick();
    check("ar_post_s_valid", 32'(s_valid), 32'd0);

    s_rdata[96 +: 32] = 32'h3333_4444;
    request(32'h0040_0000, 32'h0, 4'h0);
    tick();
    check("s3_c1_s_valid", 32'(s_valid), 32'b1000);
    tick();
    check("s3_c2_m_ready", 32'(m_ready), 32'd1);
    check("s3_c2_m_rdata", m_rdata, 32'h3333_4444);
    m_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
